stavka_c_sched: RTL and testbench

Scheduler/arbiter sharing one 4-bit load/double/increment datapath (control[2:0], data_in[3:0], data_out[3:0]) between two requesters A and B. Each requester issues one command: LOAD, LOAD-DOUBLED or INCREMENT-N. The block arbitrates, sequences the datapath control lines for the required number of cycles, and returns the datapath result with a done pulse. It sits between the requester logic and the datapath instance; it is the only driver of the datapath control and data_in.

---
 rtl/stavka_c_sched.sv | 135 +++++++++++++
 tb/tb_stavka_c_sched.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stavka_c_sched.sv
// stavka_c_sched: two-requester scheduler for a 4-bit load/double/increment datapath.
// Define STAVKA_SCHED_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module stavka_c_sched #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [CNT_W-1:0] arg_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [CNT_W-1:0] arg_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [3:0]       result,
  output logic             busy,
  output logic [2:0]       dp_control,
  output logic [3:0]       dp_data_in,
  input  logic [3:0]       dp_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_LD2 = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] arg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             own_q;
  logic             first_q;
  logic [3:0]       res_q;
  logic             take;
  logic             win_b;

  assign take = req_a | req_b;

`ifdef STAVKA_SCHED_FIXED_PRIO_EN
  assign win_b = req_b & ~req_a;
`else
  logic last_q;
  assign win_b = req_b & (~req_a | ~last_q);
`endif

  // Result is live during DONE, then held until the next completion
  assign result = (state == DONE) ? dp_data_out : res_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    done_a     = 1'b0;
    done_b     = 1'b0;
    dp_control = 3'b000;
    dp_data_in = 4'd0;
    unique case (state)
      IDLE: begin
        if (take) state_nx = EXEC;
      end
      EXEC: begin
        busy       = 1'b1;
        gnt_a      = first_q & ~own_q;
        gnt_b      = first_q & own_q;
        dp_data_in = arg_q[3:0];
        state_nx   = DONE;
        unique case (1'b1)
          (op_q == OP_LD):  dp_control = 3'b001;
          (op_q == OP_LD2): dp_control = 3'b011;
          (op_q == OP_INC && cnt_q != '0): begin
            dp_control = 3'b101;
            if (cnt_q != CNT_W'(1)) state_nx = EXEC;
          end
          default: dp_control = 3'b000;
        endcase
      end
      DONE: begin
        busy     = 1'b1;
        done_a   = ~own_q;
        done_b   = own_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command capture, repeat counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 2'b00;
      arg_q   <= '0;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      first_q <= 1'b0;
      res_q   <= 4'd0;
`ifndef STAVKA_SCHED_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      first_q <= 1'b0;
      if (state == IDLE && take) begin
        op_q    <= win_b ? op_b : op_a;
        arg_q   <= win_b ? arg_b : arg_a;
        cnt_q   <= win_b ? arg_b : arg_a;
        own_q   <= win_b;
        first_q <= 1'b1;
`ifndef STAVKA_SCHED_FIXED_PRIO_EN
        last_q  <= win_b;
`endif
      end
      if (state == EXEC && op_q == OP_INC && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (state == DONE)
        res_q <= dp_data_out;
    end
  end

endmodule

// File: tb/tb_stavka_c_sched.sv
// tb_stavka_c_sched: directed + random transactions against a
// transaction-level reference model and a behavioural datapath.
module tb_stavka_c_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [3:0] arg_a, arg_b;
  logic       gnt_a, gnt_b, done_a, done_b, busy;
  logic [3:0] result;
  logic [2:0] dp_control;
  logic [3:0] dp_data_in;
  logic [3:0] dp_q = 4'd0;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state: abstract datapath value and who was last served
  int dp_val = 0;
  bit last_b = 1'b1;

  always #5 clk = ~clk;

  stavka_c_sched #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .op_a       (op_a),
    .arg_a      (arg_a),
    .req_b      (req_b),
    .op_b       (op_b),
    .arg_b      (arg_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .done_a     (done_a),
    .done_b     (done_b),
    .result     (result),
    .busy       (busy),
    .dp_control (dp_control),
    .dp_data_in (dp_data_in),
    .dp_data_out(dp_q)
  );

  // behavioural datapath: enable / double / increment
  always @(posedge clk) begin
    if (dp_control[0]) begin
      if (dp_control[2])      dp_q <= dp_q + 4'd1;
      else if (dp_control[1]) dp_q <= 4'((int'(dp_data_in) * 2) % 16);
      else                    dp_q <= dp_data_in;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one command through the scheduler; starts and ends in IDLE, #1 after an edge
  task automatic txn(input bit ea, input int oa, input int aa,
                     input bit eb, input int ob, input int ab);
    bit wb;
    int op, arg, n, ctl, exp;
    req_a = ea; op_a = 2'(oa); arg_a = 4'(aa);
    req_b = eb; op_b = 2'(ob); arg_b = 4'(ab);
`ifdef STAVKA_SCHED_FIXED_PRIO_EN
    wb = eb && !ea;
`else
    wb = (ea && eb) ? !last_b : eb;
`endif
    last_b = wb;
    op  = wb ? ob : oa;
    arg = wb ? ab : aa;
    n   = (op == 3 && arg != 0) ? arg : 1;
    case (op)
      1:       begin ctl = 1; exp = arg; end
      2:       begin ctl = 3; exp = (arg * 2) % 16; end
      3:       begin ctl = (arg != 0) ? 5 : 0; exp = (dp_val + arg) % 16; end
      default: begin ctl = 0; exp = dp_val; end
    endcase
    @(posedge clk); #1;
    check("gnt_a", int'(gnt_a), int'(!wb));
    check("gnt_b", int'(gnt_b), int'(wb));
    if (wb) req_b = 1'b0;
    else    req_a = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) check("gnt_late", int'(gnt_a | gnt_b), 0);
      check("busy_exec", int'(busy), 1);
      check("ctl_exec", int'(dp_control), ctl);
      check("din_exec", int'(dp_data_in), arg);
      @(posedge clk); #1;
    end
    check("done_a", int'(done_a), int'(!wb));
    check("done_b", int'(done_b), int'(wb));
    check("res_done", int'(result), exp);
    check("ctl_done", int'(dp_control), 0);
    dp_val = exp;
    @(posedge clk); #1;
    check("busy_idle", int'(busy), 0);
    check("done_idle", int'(done_a | done_b), 0);
    check("res_hold", int'(result), exp);
    check("din_idle", int'(dp_data_in), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_a = 1'b1; op_a = 2'b01; arg_a = 4'd9;
    req_b = 1'b0; op_b = 2'b00; arg_b = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_gnt", int'({gnt_a, gnt_b}), 0);
    check("rst_done", int'({done_a, done_b}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res", int'(result), 0);
    check("rst_ctl", int'(dp_control), 0);
    check("rst_din", int'(dp_data_in), 0);
    rst_n = 1'b1;

    txn(1, 1, 9, 0, 0, 0);
    txn(0, 0, 0, 1, 2, 11);
    txn(1, 1, 14, 0, 0, 0);
    txn(1, 3, 3, 0, 0, 0);
    txn(1, 3, 0, 0, 0, 0);
    txn(1, 0, 5, 0, 0, 0);

    for (int i = 0; i < 4; i++) txn(1, 1, 1, 1, 1, 2);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;

    // reset during the 4th cycle of INC 10
    req_a = 1'b1; op_a = 2'b11; arg_a = 4'd10;
    @(posedge clk); #1;
    check("inc_gnt", int'(gnt_a), 1);
    req_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("inc_ctl4", int'(dp_control), 5);
    rst_n = 1'b0;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_ctl", int'(dp_control), 0);
    check("mid_done", int'({done_a, done_b}), 0);
    check("mid_res", int'(result), 0);
    dp_val = (dp_val + 3) % 16;
    last_b = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_done", int'({done_a, done_b}), 0);
    check("post_busy", int'(busy), 0);
    check("dp_after", int'(dp_q), dp_val);
    txn(1, 1, 7, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      bit ea, eb;
      ea = 1'($urandom % 2);
      eb = 1'($urandom % 2);
      if (!ea && !eb) ea = 1'b1;
      txn(ea, int'($urandom % 4), int'($urandom % 16),
          eb, int'($urandom % 4), int'($urandom % 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
